hrange_ext: RTL and testbench

// - Parametrised range generator: emits base, base+step, ... while the value is on the near side of limit.
// - Supports positive and negative steps, overflow-safe termination, an optional output-count cap and a per-value index.
// - Holds each output under _wait back-pressure. Drop-in generator for func_call designs needing wider or descending ranges.

---
 rtl/hrange_ext.sv | 125 ++++++++++++
 tb/tb_hrange_ext.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hrange_ext.sv
// Signed range generator: emits base, base+step, ... while on the near side of limit,
// with overflow-safe termination, an optional count cap and a per-value index.
module hrange_ext #(
   parameter int WIDTH     = 32,
   parameter int MAX_COUNT = 0,
   parameter int IDX_W     = 32
) (
   input  logic                    _clock,
   input  logic                    _reset,
   input  logic                    _start,
   input  logic                    _wait,
   input  logic signed [WIDTH-1:0] base,
   input  logic signed [WIDTH-1:0] limit,
   input  logic signed [WIDTH-1:0] step,
   output logic                    _valid,
   output logic                    _ready,
   output logic signed [WIDTH-1:0] _0,
   output logic [IDX_W-1:0]        _index
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

   localparam int              IW1 = IDX_W + 1;
   localparam logic [IDX_W:0]  CAP = IW1'(MAX_COUNT);

   state_e                  state_q;
   logic signed [WIDTH-1:0] base_q;
   logic signed [WIDTH-1:0] limit_q;
   logic signed [WIDTH-1:0] step_q;

   logic [WIDTH:0]          sum_ext;
   logic signed [WIDTH-1:0] next_v;
   logic                    ovf;
   logic                    under_cap;
   logic                    start_hit;
   logic                    load_hit;
   logic                    run_hit;

   function automatic logic in_range(input logic signed [WIDTH-1:0] v,
                                     input logic signed [WIDTH-1:0] lim,
                                     input logic signed [WIDTH-1:0] stp);
      if (stp == '0)
         return 1'b0;
      else if (!stp[WIDTH-1])
         return v < lim;
      else
         return v > lim;
   endfunction

   // One extra bit catches a sum that leaves the signed range instead of wrapping.
   always_comb begin
      sum_ext   = {_0[WIDTH-1], _0} + {step_q[WIDTH-1], step_q};
      next_v    = sum_ext[WIDTH-1:0];
      ovf       = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
      under_cap = (MAX_COUNT == 0) || (({1'b0, _index} + IW1'(1)) < CAP);
      start_hit = in_range(base, limit, step);
      load_hit  = in_range(base_q, limit_q, step_q);
      run_hit   = !ovf && in_range(next_v, limit_q, step_q) && under_cap;
   end

   // NOTE: all state here updates with non-blocking assignments so every register
   // sees the pre-edge values of the others, independent of statement order.
   always_ff @(posedge _clock) begin
      if (_reset) begin
         state_q <= IDLE;
         base_q  <= '0;
         limit_q <= '0;
         step_q  <= '0;
         _valid  <= 1'b0;
         _ready  <= 1'b0;
         _0      <= '0;
         _index  <= '0;
      end else if (_start) begin
         // A start in any state discards the run in flight.
         base_q  <= base;
         limit_q <= limit;
         step_q  <= step;
         _index  <= '0;
         if (_wait) begin
            state_q <= LOAD;
            _valid  <= 1'b0;
            _ready  <= 1'b0;
         end else if (start_hit) begin
            state_q <= RUN;
            _0      <= base;
            _valid  <= 1'b1;
            _ready  <= 1'b0;
         end else begin
            state_q <= DONE;
            _valid  <= 1'b0;
            _ready  <= 1'b1;
         end
      end else begin
         case (state_q)
            LOAD: begin
               if (!_wait) begin
                  if (load_hit) begin
                     state_q <= RUN;
                     _0      <= base_q;
                     _index  <= '0;
                     _valid  <= 1'b1;
                  end else begin
                     state_q <= DONE;
                     _ready  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (_valid && !_wait) begin
                  if (run_hit) begin
                     _0     <= next_v;
                     _index <= _index + IDX_W'(1);
                  end else begin
                     state_q <= DONE;
                     _valid  <= 1'b0;
                     _ready  <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hrange_ext.sv
// Directed bench for hrange_ext: default build, an 8-bit build for overflow,
// and a MAX_COUNT=3 build for the cap, all sharing one clock and control.
module tb_hrange_ext;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst, start, wt;
   logic signed [31:0] base, limit, step;
   logic signed [7:0]  b8, l8, s8;

   logic               v32, r32, vw8, rw8, vc, rc;
   logic signed [31:0] o32, oc;
   logic signed [7:0]  ow8;
   logic [31:0]        i32, iw8, ic;

   int checks = 0;
   int errors = 0;

   hrange_ext u_dut (
      ._clock(clk), ._reset(rst), ._start(start), ._wait(wt),
      .base(base), .limit(limit), .step(step),
      ._valid(v32), ._ready(r32), ._0(o32), ._index(i32)
   );

   hrange_ext #(.WIDTH(8)) u_w8 (
      ._clock(clk), ._reset(rst), ._start(start), ._wait(wt),
      .base(b8), .limit(l8), .step(s8),
      ._valid(vw8), ._ready(rw8), ._0(ow8), ._index(iw8)
   );

   hrange_ext #(.MAX_COUNT(3)) u_cap (
      ._clock(clk), ._reset(rst), ._start(start), ._wait(wt),
      .base(base), .limit(limit), .step(step),
      ._valid(vc), ._ready(rc), ._0(oc), ._index(ic)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_val(input string tag, input logic v, input logic r,
                          input logic [63:0] o, input logic [63:0] i,
                          input logic [63:0] eo, input logic [63:0] ei);
      check({tag, ".valid"}, 64'(v), 64'd1);
      check({tag, ".ready"}, 64'(r), 64'd0);
      check({tag, ".value"}, o, eo);
      check({tag, ".index"}, i, ei);
   endtask

   task automatic chk_flags(input string tag, input logic v, input logic r,
                            input logic ev, input logic er);
      check({tag, ".valid"}, 64'(v), 64'(ev));
      check({tag, ".ready"}, 64'(r), 64'(er));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_desc[4];
      exp_desc = '{10, 7, 4, 1};

      // Reset asserted together with start: reset must win.
      rst = 1'b1; start = 1'b1; wt = 1'b0;
      base = 5; limit = 9; step = 1;
      b8 = 8'sd0; l8 = 8'sd0; s8 = 8'sd0;
      tick();
      tick();
      chk_flags("reset_main", v32, r32, 1'b0, 1'b0);
      check("reset_main.value", 64'(o32), 64'd0);
      check("reset_main.index", 64'(i32), 64'd0);
      chk_flags("reset_w8", vw8, rw8, 1'b0, 1'b0);
      chk_flags("reset_cap", vc, rc, 1'b0, 1'b0);

      // Ascending 0..4, back to back.
      rst = 1'b0; start = 1'b1; base = 0; limit = 5; step = 1;
      tick();
      start = 1'b0;
      chk_val("asc0", v32, r32, 64'(o32), 64'(i32), 0, 0);
      for (int k = 1; k < 5; k++) begin
         tick();
         chk_val($sformatf("asc%0d", k), v32, r32, 64'(o32), 64'(i32), 64'(k), 64'(k));
      end
      tick();
      chk_flags("asc_done", v32, r32, 1'b0, 1'b1);
      tick();
      chk_flags("asc_done_held", v32, r32, 1'b0, 1'b1);

      // Descending 10,7,4,1.
      start = 1'b1; base = 10; limit = 0; step = -3;
      for (int k = 0; k < 4; k++) begin
         tick();
         start = 1'b0;
         chk_val($sformatf("desc%0d", k), v32, r32, 64'(o32), 64'(i32),
                 64'(exp_desc[k]), 64'(k));
      end
      tick();
      chk_flags("desc_done", v32, r32, 1'b0, 1'b1);

      // Empty ranges: zero step, and base equal to limit.
      start = 1'b1; base = 3; limit = 9; step = 0;
      tick();
      start = 1'b0;
      chk_flags("empty_step0", v32, r32, 1'b0, 1'b1);
      start = 1'b1; base = 7; limit = 7; step = 1;
      tick();
      start = 1'b0;
      chk_flags("empty_eq", v32, r32, 1'b0, 1'b1);

      // Delayed start: _wait held for 3 cycles, then 2,3.
      start = 1'b1; wt = 1'b1; base = 2; limit = 4; step = 1;
      tick();
      start = 1'b0;
      chk_flags("load0", v32, r32, 1'b0, 1'b0);
      tick();
      chk_flags("load1", v32, r32, 1'b0, 1'b0);
      tick();
      chk_flags("load2", v32, r32, 1'b0, 1'b0);
      wt = 1'b0;
      tick();
      chk_val("load_v2", v32, r32, 64'(o32), 64'(i32), 2, 0);
      tick();
      chk_val("load_v3", v32, r32, 64'(o32), 64'(i32), 3, 1);
      tick();
      chk_flags("load_done", v32, r32, 1'b0, 1'b1);

      // Stall while holding 3 for 4 cycles, then 4 follows.
      start = 1'b1; base = 3; limit = 6; step = 1;
      tick();
      start = 1'b0; wt = 1'b1;
      chk_val("stall_first", v32, r32, 64'(o32), 64'(i32), 3, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_val($sformatf("stall_hold%0d", k), v32, r32, 64'(o32), 64'(i32), 3, 0);
      end
      wt = 1'b0;
      tick();
      chk_val("stall_next", v32, r32, 64'(o32), 64'(i32), 4, 1);

      // Start while a value is pending, with _wait high: run aborted, goes to LOAD.
      start = 1'b1; wt = 1'b1; base = 50; limit = 60; step = 5;
      tick();
      start = 1'b0; wt = 1'b0;
      chk_flags("abort_load", v32, r32, 1'b0, 1'b0);
      tick();
      chk_val("abort_v50", v32, r32, 64'(o32), 64'(i32), 50, 0);
      tick();
      chk_val("abort_v55", v32, r32, 64'(o32), 64'(i32), 55, 1);
      tick();
      chk_flags("abort_done", v32, r32, 1'b0, 1'b1);

      // 8-bit overflow: 120,125 then done (130 must not wrap to -126).
      start = 1'b1; b8 = 8'sd120; l8 = 8'sd127; s8 = 8'sd5;
      tick();
      start = 1'b0;
      chk_val("w8_v120", vw8, rw8, 64'(ow8), 64'(iw8), 120, 0);
      tick();
      chk_val("w8_v125", vw8, rw8, 64'(ow8), 64'(iw8), 125, 1);
      tick();
      chk_flags("w8_done", vw8, rw8, 1'b0, 1'b1);
      b8 = 8'sd0; l8 = 8'sd0; s8 = 8'sd0;

      // Count cap of 3: 0,2,4 then done.
      start = 1'b1; base = 0; limit = 100; step = 2;
      for (int k = 0; k < 3; k++) begin
         tick();
         start = 1'b0;
         chk_val($sformatf("cap%0d", k), vc, rc, 64'(oc), 64'(ic), 64'(2 * k), 64'(k));
      end
      tick();
      chk_flags("cap_done", vc, rc, 1'b0, 1'b1);

      // Restart mid-run after 2: new base appears next cycle, cap counts afresh.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk_val("rst_mid0", vc, rc, 64'(oc), 64'(ic), 0, 0);
      tick();
      chk_val("rst_mid2", vc, rc, 64'(oc), 64'(ic), 2, 1);
      start = 1'b1; base = 20;
      tick();
      start = 1'b0;
      chk_val("restart20", vc, rc, 64'(oc), 64'(ic), 20, 0);
      tick();
      chk_val("restart22", vc, rc, 64'(oc), 64'(ic), 22, 1);
      tick();
      chk_val("restart24", vc, rc, 64'(oc), 64'(ic), 24, 2);
      tick();
      chk_flags("restart_done", vc, rc, 1'b0, 1'b1);

      // Reset during RUN with start also high.
      start = 1'b1; base = 0; limit = 100; step = 1;
      tick();
      start = 1'b0;
      chk_val("pre_reset0", v32, r32, 64'(o32), 64'(i32), 0, 0);
      tick();
      chk_val("pre_reset1", v32, r32, 64'(o32), 64'(i32), 1, 1);
      rst = 1'b1; start = 1'b1; base = 40;
      tick();
      chk_flags("run_reset", v32, r32, 1'b0, 1'b0);
      check("run_reset.value", 64'(o32), 64'd0);
      check("run_reset.index", 64'(i32), 64'd0);
      rst = 1'b0; start = 1'b0;
      tick();
      chk_flags("idle_after_reset", v32, r32, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
